// File: rtl/mic_sched_pkg.sv
// mic_sched_pkg
// Shared definitions for the mic frame scheduler slice.
//   sched_state_t : scheduler FSM states (IDLE, ARM, COLLECT)
//   DEF_*         : default channel count, sample width and stale timeout
//   MISS_W        : miss-counter width for the default timeout
package mic_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_COLLECT = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_MICS      = 3;
    localparam int DEF_SAMPLE_W      = 16;
    localparam int DEF_TIMEOUT_TICKS = 4;
    localparam int MISS_W            = $clog2(DEF_TIMEOUT_TICKS + 1);

endpackage

// File: rtl/mic_slot.sv
// mic_slot
// One capture slot per mic: latches the most recent sample of the current
// window, remembers whether one arrived (got), and tracks consecutive
// missed windows to derive the stale flag.
// Ports:
//   clk, rst   : audio clock, async active-high reset
//   valid/data : sample strobe and sample from the i2s receiver
//   close      : window close (tick while collecting)
//   clear_got  : open the first window (tick while armed)
//   clear_all  : scheduler idle; clears got, miss counter and stale
//   got/sample : window capture state, used to build the candidate frame
//   stale      : mic missed TIMEOUT_TICKS or more consecutive windows
module mic_slot
    import mic_sched_pkg::*;
#(
    parameter int SAMPLE_W      = DEF_SAMPLE_W,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int CNT_W         = MISS_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [SAMPLE_W-1:0] data,
    input  logic                close,
    input  logic                clear_got,
    input  logic                clear_all,
    output logic                got,
    output logic [SAMPLE_W-1:0] sample,
    output logic                stale
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_TICKS);

    logic [CNT_W-1:0] miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            got      <= 1'b0;
            sample   <= '0;
            miss_cnt <= '0;
            stale    <= 1'b0;
        end else if (clear_all) begin
            got      <= 1'b0;
            miss_cnt <= '0;
            stale    <= 1'b0;
        end else begin
            if (close) begin
                if (got) begin
                    miss_cnt <= '0;
                    stale    <= 1'b0;
                end else if (miss_cnt != LIMIT) begin
                    miss_cnt <= miss_cnt + 1'b1;
                    stale    <= ((miss_cnt + 1'b1) == LIMIT);
                end
            end
            // A strobe coinciding with the close/clear belongs to the new
            // window, so it overrides the got clear.
            if (valid) begin
                got    <= 1'b1;
                sample <= data;
            end else if (close || clear_got) begin
                got <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mic_frame_scheduler.sv
// mic_frame_scheduler
// Collects one sample per mic per audio tick into a time-aligned frame and
// presents it through a one-deep output register.
// Ports:
//   clk_in, rst_in      : audio clock, async active-high reset
//   enable_in           : run/stop
//   tick_in             : single-cycle frame-window strobe
//   mic_valid_in/data   : per-mic sample strobes and samples (mic i at [i*SAMPLE_W +: SAMPLE_W])
//   frame_*             : frame output, valid/ready
//   stale_out           : per-mic stale flags
//   overrun_count_out   : saturating count of frames dropped under backpressure
//   state_dbg_out       : current scheduler state
// Handshake: frame_valid_out holds with data/fresh stable until a cycle
// where frame_valid_out && frame_ready_in; that cycle is the transfer.
module mic_frame_scheduler
    import mic_sched_pkg::*;
#(
    parameter int NUM_MICS      = DEF_NUM_MICS,
    parameter int SAMPLE_W      = DEF_SAMPLE_W,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int OVR_W         = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    input  logic                         tick_in,
    input  logic [NUM_MICS-1:0]          mic_valid_in,
    input  logic [NUM_MICS*SAMPLE_W-1:0] mic_data_in,
    output logic                         frame_valid_out,
    input  logic                         frame_ready_in,
    output logic [NUM_MICS*SAMPLE_W-1:0] frame_data_out,
    output logic [NUM_MICS-1:0]          frame_fresh_out,
    output logic [NUM_MICS-1:0]          stale_out,
    output logic [OVR_W-1:0]             overrun_count_out,
    output sched_state_t                 state_dbg_out
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

    sched_state_t state, state_nxt;
    logic close, clear_got, clear_all;

    logic [NUM_MICS-1:0]          got_vec;
    logic [NUM_MICS*SAMPLE_W-1:0] cand_data;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        close     = 1'b0;
        clear_got = 1'b0;
        clear_all = 1'b0;
        if (!enable_in) begin
            state_nxt = ST_IDLE;
            clear_all = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ARM;
                    clear_all = 1'b1;
                end
                ST_ARM: begin
                    // First tick only opens a window; the partial one is dropped.
                    if (tick_in) begin
                        clear_got = 1'b1;
                        state_nxt = ST_COLLECT;
                    end
                end
                ST_COLLECT: close = tick_in;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    assign state_dbg_out = state;

    // ---------------- Slots ----------------
    for (genvar i = 0; i < NUM_MICS; i++) begin : g_slot
        logic [SAMPLE_W-1:0] sample;

        mic_slot #(
            .SAMPLE_W      (SAMPLE_W),
            .TIMEOUT_TICKS (TIMEOUT_TICKS),
            .CNT_W         (CNT_W)
        ) u_slot (
            .clk       (clk_in),
            .rst       (rst_in),
            .valid     (mic_valid_in[i]),
            .data      (mic_data_in[i*SAMPLE_W +: SAMPLE_W]),
            .close     (close),
            .clear_got (clear_got),
            .clear_all (clear_all),
            .got       (got_vec[i]),
            .sample    (sample),
            .stale     (stale_out[i])
        );

        assign cand_data[i*SAMPLE_W +: SAMPLE_W] = got_vec[i] ? sample : '0;
    end

    // ---------------- Output register ----------------
    logic accept, load;
    assign accept = frame_valid_out & frame_ready_in;
    assign load   = close & (~frame_valid_out | frame_ready_in);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_valid_out   <= 1'b0;
            frame_data_out    <= '0;
            frame_fresh_out   <= '0;
            overrun_count_out <= '0;
        end else if (close) begin
            if (load) begin
                frame_valid_out <= 1'b1;
                frame_data_out  <= cand_data;
                frame_fresh_out <= got_vec;
            end else if (overrun_count_out != '1) begin
                overrun_count_out <= overrun_count_out + 1'b1;
            end
        end else if (accept) begin
            frame_valid_out <= 1'b0;
        end
    end

endmodule
